// File: rtl/ysyx_220066_div.sv
// ysyx_220066_div -- multi-cycle RV64 integer divider (DIV/DIVU/REM/REMU and
// their W forms) using restoring radix-2 division on operand magnitudes.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   in_valid/ready   op offer / divider idle
//   op               00 DIV, 01 DIVU, 10 REM, 11 REMU
//   is_word          32-bit W variant (result sign-extended to 64 bits)
//   src1, src2       dividend, divisor
//   rd_in, nxtpc_in, error_in   tags carried through to the result
//   flush            synchronous kill of whatever is in flight
//   div_block        consumer has not taken the result yet; hold it
//   Div_*_in         result valid, destination, data and tags
//   dbg_state        current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: an op transfers on a rising edge where in_valid=1 and
// in_ready=1 (state IDLE) and flush=0. The result is offered with
// Div_wen_in=1 and held unchanged until an edge with div_block=0, after which
// the divider returns to IDLE; it never accepts on that same edge.
module ysyx_220066_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic        is_word,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic [4:0]  rd_in,
  input  logic [63:0] nxtpc_in,
  input  logic        error_in,
  input  logic        flush,
  input  logic        div_block,
  output logic        Div_wen_in,
  output logic [4:0]  Div_rd_in,
  output logic [63:0] Div_data_in,
  output logic [63:0] Div_nxtpc_in,
  output logic        Div_error_in,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [6:0]  cnt;
  logic [63:0] rem_q, quo_q, dvs_q;
  logic        word_q, is_rem_q, neg_quo_q, neg_rem_q;

  // ---------------- operand preparation at accept ----------------
  logic        is_signed, is_rem;
  logic [63:0] a_ext, b_ext, a_mag, b_mag, a_sext32;
  logic        div_zero, overflow;
  logic [63:0] special_res;

  assign is_signed = ~op[0];
  assign is_rem    = op[1];
  assign a_sext32  = {{32{src1[31]}}, src1[31:0]};

  always_comb begin
    a_ext = src1;
    b_ext = src2;
    if (is_word) begin
      a_ext = is_signed ? a_sext32 : {32'd0, src1[31:0]};
      b_ext = is_signed ? {{32{src2[31]}}, src2[31:0]} : {32'd0, src2[31:0]};
    end
    a_mag = (is_signed && a_ext[63]) ? (64'd0 - a_ext) : a_ext;
    b_mag = (is_signed && b_ext[63]) ? (64'd0 - b_ext) : b_ext;
  end

  assign div_zero = (b_ext == 64'd0);
  assign overflow = is_signed && (b_ext == {64{1'b1}}) &&
                    (a_ext == (is_word ? 64'hFFFF_FFFF_8000_0000
                                       : 64'h8000_0000_0000_0000));

  // Both special cases report the dividend (sign-extended for W forms) in
  // one of the two slots: as remainder on /0, as quotient on overflow.
  always_comb begin
    special_res = is_word ? a_sext32 : src1;
    if (div_zero)
      special_res = is_rem ? (is_word ? a_sext32 : src1) : {64{1'b1}};
    else if (overflow)
      special_res = is_rem ? 64'd0 : (is_word ? a_sext32 : src1);
  end

  // ---------------- one restoring iteration ----------------
  // The partial remainder is shifted left with the next dividend bit; it can
  // need 65 bits before the trial subtraction.
  logic [64:0] shifted, trial;
  logic [63:0] rem_nx, quo_nx, quo_fix, rem_fix, res_sel, final_res;

  always_comb begin
    shifted = {rem_q, quo_q[63]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[64]) begin
      rem_nx = trial[63:0];
      quo_nx = {quo_q[62:0], 1'b1};
    end else begin
      rem_nx = shifted[63:0];
      quo_nx = {quo_q[62:0], 1'b0};
    end
    quo_fix   = neg_quo_q ? (64'd0 - quo_nx) : quo_nx;
    rem_fix   = neg_rem_q ? (64'd0 - rem_nx) : rem_nx;
    res_sel   = is_rem_q ? rem_fix : quo_fix;
    final_res = word_q ? {{32{res_sel[31]}}, res_sel[31:0]} : res_sel;
  end

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 7'd0;
      rem_q        <= 64'd0;
      quo_q        <= 64'd0;
      dvs_q        <= 64'd0;
      word_q       <= 1'b0;
      is_rem_q     <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      Div_wen_in   <= 1'b0;
      Div_rd_in    <= 5'd0;
      Div_data_in  <= 64'd0;
      Div_nxtpc_in <= 64'd0;
      Div_error_in <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= 7'd0;
      Div_wen_in <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            Div_rd_in    <= rd_in;
            Div_nxtpc_in <= nxtpc_in;
            Div_error_in <= error_in;
            word_q       <= is_word;
            is_rem_q     <= is_rem;
            neg_quo_q    <= is_signed && (a_ext[63] ^ b_ext[63]);
            neg_rem_q    <= is_signed && a_ext[63];
            if (div_zero || overflow) begin
              state       <= DONE;
              Div_wen_in  <= 1'b1;
              Div_data_in <= special_res;
            end else begin
              state <= CALC;
              rem_q <= 64'd0;
              dvs_q <= b_mag;
              // W forms start with the 32-bit magnitude in the top half so
              // the same MSB-first shift produces the quotient in bits 31:0.
              quo_q <= is_word ? {a_mag[31:0], 32'd0} : a_mag;
              cnt   <= is_word ? 7'd32 : 7'd64;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            state       <= DONE;
            Div_wen_in  <= 1'b1;
            Div_data_in <= final_res;
          end
        end
        DONE: begin
          if (!div_block) begin
            state      <= IDLE;
            Div_wen_in <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          Div_wen_in <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_220066_div.sv
module tb_ysyx_220066_div;

  logic        clk, rst, in_valid, in_ready, is_word, error_in, flush, div_block;
  logic [1:0]  op;
  logic [63:0] src1, src2, nxtpc_in;
  logic [4:0]  rd_in;
  logic        Div_wen_in, Div_error_in;
  logic [4:0]  Div_rd_in;
  logic [63:0] Div_data_in, Div_nxtpc_in;
  logic [1:0]  dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];

  ysyx_220066_div dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .is_word(is_word), .src1(src1), .src2(src2),
    .rd_in(rd_in), .nxtpc_in(nxtpc_in), .error_in(error_in),
    .flush(flush), .div_block(div_block),
    .Div_wen_in(Div_wen_in), .Div_rd_in(Div_rd_in), .Div_data_in(Div_data_in),
    .Div_nxtpc_in(Div_nxtpc_in), .Div_error_in(Div_error_in),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] pc, input logic e);
    @(negedge clk);
    op = o; is_word = w; src1 = a; src2 = b; rd_in = rd; nxtpc_in = pc;
    error_in = e; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counted so a result visible right after the accept edge is 1.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!Div_wen_in && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Counts cycles with Div_wen_in high over a window.
  task automatic watch_no_wen(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (Div_wen_in) seen++;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int lat, seen;
    logic [63:0] pc, held;
    logic        e;
    logic [63:0] exp_d;

    vecs[0]  = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65};
    vecs[1]  = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{2'b01, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[3]  = '{2'b11, 1'b0, 64'h1234, 64'd0, 64'h1234, 1};
    vecs[4]  = '{2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[5]  = '{2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};
    vecs[6]  = '{2'b01, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'd2, 64'd3, 33};
    vecs[7]  = '{2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    vecs[8]  = '{2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    vecs[9]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[10] = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[11] = '{2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[12] = '{2'b00, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[13] = '{2'b00, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[14] = '{2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[15] = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1};
    vecs[16] = '{2'b11, 1'b1, 64'hFFFF_FFFF_8000_0005, 64'hAAAA_AAAA_0000_0000, 64'hFFFF_FFFF_8000_0005, 1};

    rst = 1'b0; in_valid = 1'b0; op = 2'b00; is_word = 1'b0; src1 = '0; src2 = '0;
    rd_in = '0; nxtpc_in = '0; error_in = 1'b0; flush = 1'b0; div_block = 1'b0;
    #22;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_wen", {63'd0, Div_wen_in}, 64'd0);
    check("reset_data", Div_data_in, 64'd0);
    check("reset_rd", {59'd0, Div_rd_in}, 64'd0);
    check("reset_pc", Div_nxtpc_in, 64'd0);
    check("reset_err", {63'd0, Div_error_in}, 64'd0);
    check("reset_state", {62'd0, dbg_state}, 64'd0);
    rst = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 17; i++) begin
      pc = {$urandom, $urandom};
      e  = 1'($urandom_range(0, 1));
      check($sformatf("v%0d_ready", i), {63'd0, in_ready}, 64'd1);
      exp_q.push_back(vecs[i].exp);
      issue(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 5'(i + 1), pc, e);
      wait_result(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      exp_d = exp_q.pop_front();
      check($sformatf("v%0d_data", i), Div_data_in, exp_d);
      check($sformatf("v%0d_rd", i), {59'd0, Div_rd_in}, 64'(i + 1));
      check($sformatf("v%0d_pc", i), Div_nxtpc_in, pc);
      check($sformatf("v%0d_err", i), {63'd0, Div_error_in}, {63'd0, e});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_exit_wen", i), {63'd0, Div_wen_in}, 64'd0);
      check($sformatf("v%0d_exit_ready", i), {63'd0, in_ready}, 64'd1);
    end

    // ---------------- div_block hold, no accept on exit edge ----------------
    div_block = 1'b1;
    issue(2'b01, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'd2, 5'd9, 64'h100, 1'b0);
    wait_result(lat);
    check("blk_latency", 64'(lat), 64'd33);
    held = Div_data_in;
    check("blk_data", held, 64'd3);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("blk_hold%0d_data", k), Div_data_in, 64'd3);
      check($sformatf("blk_hold%0d_wen", k), {63'd0, Div_wen_in}, 64'd1);
      check($sformatf("blk_hold%0d_ready", k), {63'd0, in_ready}, 64'd0);
    end
    // Offer a new op on the exit edge; it must only be taken one edge later.
    div_block = 1'b0;
    op = 2'b01; is_word = 1'b0; src1 = 64'd100; src2 = 64'd7; rd_in = 5'd4;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("exit_no_accept_ready", {63'd0, in_ready}, 64'd1);
    check("exit_wen", {63'd0, Div_wen_in}, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("late_accept_ready", {63'd0, in_ready}, 64'd0);
    wait_result(lat);
    check("late_latency", 64'(lat), 64'd65);
    check("late_data", Div_data_in, 64'd14);
    @(posedge clk);
    #1;

    // ---------------- flush mid-CALC ----------------
    issue(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd5, 64'h200, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_ready", {63'd0, in_ready}, 64'd1);
    watch_no_wen(80, seen);
    check("flush_no_wen", 64'(seen), 64'd0);

    // flush together with in_valid in IDLE: nothing accepted
    @(negedge clk);
    op = 2'b01; is_word = 1'b0; src1 = 64'd5; src2 = 64'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_valid_ready", {63'd0, in_ready}, 64'd1);
    watch_no_wen(5, seen);
    check("flush_vs_valid_no_wen", 64'(seen), 64'd0);

    // ---------------- reset mid-CALC ----------------
    issue(2'b01, 1'b0, 64'd1000, 64'd9, 5'd7, 64'h300, 1'b1);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_ready", {63'd0, in_ready}, 64'd1);
    check("rst_mid_wen", {63'd0, Div_wen_in}, 64'd0);
    check("rst_mid_rd", {59'd0, Div_rd_in}, 64'd0);
    check("rst_mid_data", Div_data_in, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    watch_no_wen(80, seen);
    check("rst_mid_no_wen", 64'(seen), 64'd0);
    check("rst_mid_ready_after", {63'd0, in_ready}, 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
